register_file: RTL and testbench



---
 rtl/cpu_pkg.sv | 16 +
 rtl/register_file_if.sv | 39 +++
 rtl/rf_read_port.sv | 35 +++
 rtl/register_file.sv | 88 ++++++++
 tb/tb_register_file.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// Provides the default register-file geometry, the architectural register
// indices that carry special meaning ($zero, $sp), the $sp reset value,
// and the address/word types used across the datapath.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int SP_RESET = 128;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/register_file_if.sv
// Register-file bus interface.
// Groups the operand read ports (rs/rt), the debug read port, the
// write-back register write and the HI/LO write from the multiply unit.
//   master : datapath side, drives addresses/write data, receives read data
//   slave  : register file side
interface register_file_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
);

  logic [ADDR_W-1:0]   rs_addr_i;
  logic [ADDR_W-1:0]   rt_addr_i;
  logic [DATA_W-1:0]   rs_data_o;
  logic [DATA_W-1:0]   rt_data_o;
  logic                reg_write_i;
  logic [ADDR_W-1:0]   rd_addr_i;
  logic [DATA_W-1:0]   rd_data_i;
  logic                hilo_write_i;
  logic [2*DATA_W-1:0] hilo_data_i;
  logic [DATA_W-1:0]   hi_o;
  logic [DATA_W-1:0]   lo_o;
  logic [ADDR_W-1:0]   dbg_addr_i;
  logic [DATA_W-1:0]   dbg_data_o;

  modport master (
    output rs_addr_i, rt_addr_i, reg_write_i, rd_addr_i, rd_data_i,
    output hilo_write_i, hilo_data_i, dbg_addr_i,
    input  rs_data_o, rt_data_o, hi_o, lo_o, dbg_data_o
  );

  modport slave (
    input  rs_addr_i, rt_addr_i, reg_write_i, rd_addr_i, rd_data_i,
    input  hilo_write_i, hilo_data_i, dbg_addr_i,
    output rs_data_o, rt_data_o, hi_o, lo_o, dbg_data_o
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational register-file read port.
// Ports:
//   i_addr      read address
//   i_regs      full storage array
//   i_wr_en     register write enable of the current cycle
//   i_wr_addr   register write address of the current cycle
//   i_wr_data   register write data of the current cycle
//   i_byp_en    allow same-cycle write data to be forwarded
//   o_data      read data
// Address 0 always reads 0, even if a write to 0 is being presented.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0]                    i_addr,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   i_regs,
  input  logic                                 i_wr_en,
  input  logic [ADDR_W-1:0]                    i_wr_addr,
  input  logic [DATA_W-1:0]                    i_wr_data,
  input  logic                                 i_byp_en,
  output logic [DATA_W-1:0]                    o_data
);

  always_comb begin
    o_data = i_regs[i_addr];
    if (i_addr == ADDR_W'(REG_ZERO)) begin
      o_data = '0;
    end else if (i_byp_en && i_wr_en && (i_wr_addr == i_addr)) begin
      o_data = i_wr_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file for the single-cycle MIPS datapath:
// 32 general-purpose registers plus HI/LO.
// Ports:
//   clk_i  clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset
//   rf     register_file_if.slave: rs/rt/dbg reads, register write,
//          HI/LO write and HI/LO read-out
// With BYPASS=1 a write presented this cycle is already visible on the
// rs/rt and HI/LO outputs; the debug port always shows stored state.
module register_file
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int BYPASS   = 1,
  parameter int SP_RESET = cpu_pkg::SP_RESET
) (
  input  logic             clk_i,
  input  logic             rst_n,
  register_file_if.slave   rf
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] r_regs;
  logic [DATA_W-1:0]           r_hi;
  logic [DATA_W-1:0]           r_lo;

  logic w_byp_en;
  logic w_hilo_byp;

  // Forwarding is suppressed while reset is asserted: the write is lost,
  // so it must not appear on the outputs either.
  assign w_byp_en   = (BYPASS != 0) & rst_n;
  assign w_hilo_byp = w_byp_en & rf.hilo_write_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == REG_SP) ? DATA_W'(SP_RESET) : '0;
      end
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (rf.reg_write_i && (rf.rd_addr_i != ADDR_W'(REG_ZERO))) begin
        r_regs[rf.rd_addr_i] <= rf.rd_data_i;
      end
      if (rf.hilo_write_i) begin
        r_hi <= rf.hilo_data_i[2*DATA_W-1:DATA_W];
        r_lo <= rf.hilo_data_i[DATA_W-1:0];
      end
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_port (
    .i_addr    (rf.rs_addr_i),
    .i_regs    (r_regs),
    .i_wr_en   (rf.reg_write_i),
    .i_wr_addr (rf.rd_addr_i),
    .i_wr_data (rf.rd_data_i),
    .i_byp_en  (w_byp_en),
    .o_data    (rf.rs_data_o)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_port (
    .i_addr    (rf.rt_addr_i),
    .i_regs    (r_regs),
    .i_wr_en   (rf.reg_write_i),
    .i_wr_addr (rf.rd_addr_i),
    .i_wr_data (rf.rd_data_i),
    .i_byp_en  (w_byp_en),
    .o_data    (rf.rt_data_o)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg_port (
    .i_addr    (rf.dbg_addr_i),
    .i_regs    (r_regs),
    .i_wr_en   (rf.reg_write_i),
    .i_wr_addr (rf.rd_addr_i),
    .i_wr_data (rf.rd_data_i),
    .i_byp_en  (1'b0),
    .o_data    (rf.dbg_data_o)
  );

  assign rf.hi_o = w_hilo_byp ? rf.hilo_data_i[2*DATA_W-1:DATA_W] : r_hi;
  assign rf.lo_o = w_hilo_byp ? rf.hilo_data_i[DATA_W-1:0]        : r_lo;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: one instance with BYPASS=1 and one with
// BYPASS=0 see identical stimulus. A reference model (plain arrays)
// predicts every output of both instances; predictions are queued by the
// stimulus process and checked by a monitor on the falling clock edge.
module tb_register_file;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  register_file_if #(.DATA_W(32), .ADDR_W(5)) ifb1 ();
  register_file_if #(.DATA_W(32), .ADDR_W(5)) ifb0 ();

  register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .SP_RESET(128)) dut1 (
    .clk_i (clk),
    .rst_n (rst_n),
    .rf    (ifb1.slave)
  );

  register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .SP_RESET(128)) dut0 (
    .clk_i (clk),
    .rst_n (rst_n),
    .rf    (ifb0.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] rs1, rt1, hi1, lo1;
    logic [31:0] rs0, rt0, hi0, lo0;
    logic [31:0] dbg;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: value each register holds after the last edge.
  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo;
  bit          m_known = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] model_read(int a, bit byp, bit rst_ok, bit we,
                                             int rd, logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (byp && rst_ok && we && rd == a) return wd;
    return m_regs[a];
  endfunction

  task automatic cycle(string tag, bit rst_ok, bit we, int rd, logic [31:0] wd,
                       bit hw, logic [63:0] hd, int rs, int rt, int dbg);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst_ok;
    ifb1.reg_write_i = we;            ifb0.reg_write_i = we;
    ifb1.rd_addr_i = 5'(rd);          ifb0.rd_addr_i = 5'(rd);
    ifb1.rd_data_i = wd;              ifb0.rd_data_i = wd;
    ifb1.hilo_write_i = hw;           ifb0.hilo_write_i = hw;
    ifb1.hilo_data_i = hd;            ifb0.hilo_data_i = hd;
    ifb1.rs_addr_i = 5'(rs);          ifb0.rs_addr_i = 5'(rs);
    ifb1.rt_addr_i = 5'(rt);          ifb0.rt_addr_i = 5'(rt);
    ifb1.dbg_addr_i = 5'(dbg);        ifb0.dbg_addr_i = 5'(dbg);
    if (m_known) begin
      e.tag = tag;
      e.rs1 = model_read(rs, 1'b1, rst_ok, we, rd, wd);
      e.rt1 = model_read(rt, 1'b1, rst_ok, we, rd, wd);
      e.rs0 = model_read(rs, 1'b0, rst_ok, we, rd, wd);
      e.rt0 = model_read(rt, 1'b0, rst_ok, we, rd, wd);
      e.dbg = model_read(dbg, 1'b0, rst_ok, we, rd, wd);
      e.hi1 = (rst_ok && hw) ? hd[63:32] : m_hi;
      e.lo1 = (rst_ok && hw) ? hd[31:0]  : m_lo;
      e.hi0 = m_hi;
      e.lo0 = m_lo;
      exp_q.push_back(e);
    end
    // State after the coming edge.
    if (!rst_ok) begin
      for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'd128 : 32'd0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (we && rd != 0) m_regs[rd] = wd;
      if (hw) begin
        m_hi = hd[63:32];
        m_lo = hd[31:0];
      end
    end
  endtask

  task automatic idle(string tag, int rs, int rt, int dbg);
    cycle(tag, 1'b1, 1'b0, 0, 32'h0, 1'b0, 64'h0, rs, rt, dbg);
  endtask

  task automatic chk(string tag, string fld, logic [31:0] act, logic [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, req);
    end
  endtask

  // Monitor: every cycle with a queued prediction is one vector.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        chk(e.tag, "rs_b1",  ifb1.rs_data_o,  e.rs1);
        chk(e.tag, "rt_b1",  ifb1.rt_data_o,  e.rt1);
        chk(e.tag, "hi_b1",  ifb1.hi_o,       e.hi1);
        chk(e.tag, "lo_b1",  ifb1.lo_o,       e.lo1);
        chk(e.tag, "dbg_b1", ifb1.dbg_data_o, e.dbg);
        chk(e.tag, "rs_b0",  ifb0.rs_data_o,  e.rs0);
        chk(e.tag, "rt_b0",  ifb0.rt_data_o,  e.rt0);
        chk(e.tag, "hi_b0",  ifb0.hi_o,       e.hi0);
        chk(e.tag, "lo_b0",  ifb0.lo_o,       e.lo0);
        chk(e.tag, "dbg_b0", ifb0.dbg_data_o, e.dbg);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          r_ok, r_we, r_hw;
    int          r_rd, r_rs, r_rt;
    logic [31:0] r_wd;
    logic [63:0] r_hd;

    // Reset held for two edges, with a write presented that must be lost.
    cycle("reset0", 1'b0, 1'b1, 29, 32'h55, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 29, 29, 29);
    cycle("reset1", 1'b0, 1'b1, 3, 32'hABCD, 1'b1, 64'h1234_5678_9ABC_DEF0, 3, 29, 3);
    for (int i = 0; i < 32; i++) idle("reset_dump", i, 31 - i, i);

    // Write / readback.
    cycle("wr8", 1'b1, 1'b1, 8, 32'hDEADBEEF, 1'b0, 64'h0, 1, 2, 8);
    idle("rd8", 8, 8, 8);

    // Zero register.
    cycle("wr0", 1'b1, 1'b1, 0, 32'hFFFFFFFF, 1'b0, 64'h0, 0, 0, 0);
    idle("rd0", 0, 0, 0);

    // Bypass of a fresh write.
    cycle("byp5", 1'b1, 1'b1, 5, 32'h12345678, 1'b0, 64'h0, 5, 5, 5);
    idle("rd5", 5, 8, 5);

    // HI/LO write together with a register write.
    cycle("hilo_wr2", 1'b1, 1'b1, 2, 32'd7, 1'b1, 64'h00000001_80000000, 2, 0, 2);
    idle("hilo_rd", 2, 2, 2);

    // Reset beats write to $sp.
    cycle("rst_sp", 1'b0, 1'b1, 29, 32'h55, 1'b1, 64'h5555_5555_AAAA_AAAA, 29, 8, 29);
    idle("rd_sp", 29, 8, 29);

    // First post-reset write lands immediately.
    cycle("post_rst_wr", 1'b1, 1'b1, 29, 32'h55, 1'b0, 64'h0, 29, 29, 29);
    idle("post_rst_rd", 29, 29, 29);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      r_ok = ($urandom_range(0, 39) != 0);
      r_we = $urandom_range(0, 1) != 0;
      r_hw = $urandom_range(0, 3) == 0;
      r_rd = $urandom_range(0, 31);
      r_wd = $urandom;
      r_hd = {$urandom, $urandom};
      r_rs = ($urandom_range(0, 2) == 0) ? r_rd : $urandom_range(0, 31);
      r_rt = ($urandom_range(0, 2) == 0) ? r_rs : $urandom_range(0, 31);
      cycle("rand", r_ok, r_we, r_rd, r_wd, r_hw, r_hd, r_rs, r_rt, $urandom_range(0, 31));
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
